counter_sequencer: RTL

//   Shares one WIDTH-bit down-counter between NREQ requesters that need timed intervals.

---
 rtl/counter_sequencer_pkg.sv | 23 ++
 rtl/counter_sequencer_rr_pick.sv | 34 +++
 rtl/counter_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: FSM state codes,
// default fixture sizes and a small index-width helper.
package counter_sequencer_pkg;

   // FSM state codes
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Default sizes for the counter fixtures
   localparam int DEF_WIDTH    = 4;
   localparam int DEF_NREQ     = 4;
   localparam int DEF_PRE_LOG2 = 2;

   // Bits needed to hold a requester index (never less than one)
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/counter_sequencer_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches req_i starting one
// position above last_i, wrapping at NREQ, and reports the first set bit.
module rr_pick
   import counter_sequencer_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int IDX_W = idx_width(NREQ)
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [NREQ-1:0]  onehot_o,
   output logic [IDX_W-1:0] index_o,
   output logic             any_o
);

   logic [IDX_W-1:0] cand;

   // Rotating priority search: the previous winner is checked last
   always_comb begin
      onehot_o = '0;
      index_o  = '0;
      any_o    = 1'b0;
      cand     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDX_W'((int'(last_i) + k) % NREQ);
         if (!any_o && req_i[cand]) begin
            any_o          = 1'b1;
            index_o        = cand;
            onehot_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: shares one down-counter between NREQ requesters.
// Round-robin grant, load of the owner's interval, countdown, one-cycle
// terminal-count pulse, then release. Dropping req while owning aborts.
// Optional feature: define COUNTER_PRESCALE_EN to decrement only every
// 2**PRE_LOG2 cycles while counting.
module counter_sequencer
   import counter_sequencer_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int NREQ     = DEF_NREQ,
   parameter int PRE_LOG2 = DEF_PRE_LOG2
) (
   input  logic                    CLOCK,
   input  logic                    CLEAR_N,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   load_val,
   output logic [NREQ-1:0]         grant,
   output logic                    busy,
   output logic [WIDTH-1:0]        count,
   output logic [NREQ-1:0]         done
);

   localparam int IDX_W = idx_width(NREQ);

   // Reject unsupported configurations at elaboration
   if (NREQ < 2 || NREQ > 8 || WIDTH < 1 || PRE_LOG2 < 0) begin : g_param_check
      $error("counter_sequencer: parameter out of range");
   end

   state_e            state_q, state_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]  last_q,  last_d;
   logic [WIDTH-1:0]  count_q, count_d;

   logic [NREQ-1:0]   pick_onehot;
   logic [IDX_W-1:0]  pick_index;
   logic              pick_any;
   logic              owner_req;
   logic [WIDTH-1:0]  owner_val;
   logic              tick;

   rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i    (req),
      .last_i   (last_q),
      .onehot_o (pick_onehot),
      .index_o  (pick_index),
      .any_o    (pick_any)
   );

   // The owner still wants the counter while its request stays high
   assign owner_req = |(req & grant_q);

   // Select the owner's interval through the one-hot grant
   always_comb begin
      owner_val = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grant_q[k]) begin
            owner_val = owner_val | load_val[k*WIDTH +: WIDTH];
         end
      end
   end

`ifdef COUNTER_PRESCALE_EN
   localparam int              PRE_W   = (PRE_LOG2 > 0) ? PRE_LOG2 : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'((1 << PRE_LOG2) - 1);

   logic [PRE_W-1:0] pre_q, pre_d;

   assign tick = (pre_q == PRE_MAX);

   // Prescaler restarts while loading and free-runs only inside RUN
   always_comb begin
      pre_d = pre_q;
      if (state_q == ST_LOAD) begin
         pre_d = '0;
      end else if (state_q == ST_RUN) begin
         pre_d = tick ? '0 : pre_q + 1'b1;
      end
   end

   // Prescaler register
   always_ff @(posedge CLOCK or negedge CLEAR_N) begin
      if (!CLEAR_N) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end
`else
   assign tick = 1'b1;
`endif

   // Next-state logic: arbitration, load, countdown, release and abort
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d = pick_onehot;
               last_d  = pick_index;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (!owner_req) begin
               grant_d = '0;
               count_d = '0;
               state_d = ST_IDLE;
            end else begin
               count_d = owner_val;
               state_d = (owner_val == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (!owner_req) begin
               grant_d = '0;
               count_d = '0;
               state_d = ST_IDLE;
            end else if (tick) begin
               // Count == 1 is the last step; never go below zero
               if (count_q <= WIDTH'(1)) begin
                  count_d = '0;
                  state_d = ST_DONE;
               end else begin
                  count_d = count_q - 1'b1;
               end
            end
         end
         ST_DONE: begin
            grant_d = '0;
            count_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = '0;
            count_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, grant, round-robin pointer and counter registers
   always_ff @(posedge CLOCK or negedge CLEAR_N) begin
      if (!CLEAR_N) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(NREQ - 1);
         count_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         count_q <= count_d;
      end
   end

   // Outputs come straight from registered state
   assign grant = grant_q;
   assign busy  = (state_q != ST_IDLE);
   assign count = count_q;
   assign done  = (state_q == ST_DONE) ? grant_q : '0;

endmodule
